// File: rtl/seven_segment_scan_controller_if.sv
// Display-side bundle for the seven-segment scanner: shadowed display inputs
// from the datapath and the registered pin/timing outputs back to the board.
interface seven_segment_scan_controller_if #(
  parameter int NUM_DIGITS = 3
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digit_values;
  logic [NUM_DIGITS-1:0]   dp_values;
  logic [NUM_DIGITS-1:0]   digit_enable;
  logic [3:0]              brightness;
  logic [7:0]              display_bits;
  logic [NUM_DIGITS-1:0]   digit_select;
  logic                    digit_change_tick;
  logic                    frame_tick;
  logic [IDX_W-1:0]        active_digit;

  modport master (
    output digit_values, dp_values, digit_enable, brightness,
    input  display_bits, digit_select, digit_change_tick, frame_tick, active_digit
  );

  modport slave (
    input  digit_values, dp_values, digit_enable, brightness,
    output display_bits, digit_select, digit_change_tick, frame_tick, active_digit
  );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed seven-segment scanner with per-slot dead time, PWM brightness,
// blanking, decimal points and frame-coherent shadowing of the display inputs.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS      = 3,
  parameter int TICKS_PER_DIGIT = 1000,
  parameter int BLANK_CYCLES    = 16,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit SEL_ACTIVE_LOW  = 1'b1
) (
  input logic clk,
  input logic reset,
  seven_segment_scan_controller_if.slave bus
);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W   = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int PRD_W   = CNT_W + 5;
  localparam int ON_SPAN = TICKS_PER_DIGIT - BLANK_CYCLES;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [3:0]              bri_q, bri_d;
  logic [7:0]              bits_q, bits_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    dct_q, dct_d;
  logic                    ft_q, ft_d;
  logic [IDX_W-1:0]        act_q, act_d;

  logic                    load_s;
  logic [3:0]              nib_s;
  logic                    dp_s;
  logic                    en_s;
  logic                    on_s;
  logic [PRD_W-1:0]        prod_s;
  logic [PRD_W-1:0]        lit_s;
  logic [PRD_W-1:0]        cnt_ext_s;
  logic [7:0]              seg_lit_s;
  logic [NUM_DIGITS-1:0]   sel_hot_s;

  // Counters, shadow capture and next output image; the _d shadows double as the
  // effective values so the frame's first slot already shows freshly captured data.
  always_comb begin
    load_s = (cnt_q == '0) && (idx_q == '0);
    val_d  = val_q;
    dp_d   = dp_q;
    en_d   = en_q;
    bri_d  = bri_q;
    if (load_s) begin
      val_d = bus.digit_values;
      dp_d  = bus.dp_values;
      en_d  = bus.digit_enable;
      bri_d = bus.brightness;
    end else begin
      val_d = val_q;
    end

    if (cnt_q == CNT_W'(TICKS_PER_DIGIT - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
    end

    nib_s = 4'h0;
    dp_s  = 1'b0;
    en_s  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_s = val_d[4*k +: 4];
        dp_s  = dp_d[k];
        en_s  = en_d[k];
      end else begin
        nib_s = nib_s;
      end
    end

    prod_s    = PRD_W'(ON_SPAN) * PRD_W'(bri_d);
    lit_s     = (bri_d == 4'hF) ? PRD_W'(ON_SPAN) : (prod_s >> 4);
    cnt_ext_s = PRD_W'(cnt_q);
    on_s      = en_s && (cnt_ext_s >= PRD_W'(BLANK_CYCLES)) &&
                (cnt_ext_s < (PRD_W'(BLANK_CYCLES) + lit_s));

    sel_hot_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sel_hot_s[k] = on_s && (idx_q == IDX_W'(k));
    end
    seg_lit_s = on_s ? {dp_s, hex_decode(nib_s)} : 8'h00;

    bits_d = seg_lit_s ^ {8{SEG_ACTIVE_LOW}};
    sel_d  = sel_hot_s ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
    dct_d  = (cnt_q == '0);
    ft_d   = load_s;
    act_d  = idx_q;
  end

  // State and output registers; reset forces every pin to its inactive level.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      val_q  <= '0;
      dp_q   <= '0;
      en_q   <= '0;
      bri_q  <= 4'h0;
      bits_q <= {8{SEG_ACTIVE_LOW}};
      sel_q  <= {NUM_DIGITS{SEL_ACTIVE_LOW}};
      dct_q  <= 1'b0;
      ft_q   <= 1'b0;
      act_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      val_q  <= val_d;
      dp_q   <= dp_d;
      en_q   <= en_d;
      bri_q  <= bri_d;
      bits_q <= bits_d;
      sel_q  <= sel_d;
      dct_q  <= dct_d;
      ft_q   <= ft_d;
      act_q  <= act_d;
    end
  end

  assign bus.display_bits      = bits_q;
  assign bus.digit_select      = sel_q;
  assign bus.digit_change_tick = dct_q;
  assign bus.frame_tick        = ft_q;
  assign bus.active_digit      = act_q;
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for the scanner: a time-indexed model of the display checked every cycle,
// plus hand-computed pin values at chosen points of the scan.
module tb_seven_segment_scan_controller;
  localparam int N  = 3;
  localparam int T  = 20;
  localparam int B  = 4;
  localparam int ON = T - B;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   pos    = 0;

  seven_segment_scan_controller_if #(.NUM_DIGITS(N)) bus ();

  seven_segment_scan_controller #(
    .NUM_DIGITS(N), .TICKS_PER_DIGIT(T), .BLANK_CYCLES(B),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at pos %0d: got %h expected %h", name, pos, act, exp);
    end
  endtask

  // Reference model: time n since reset release determines slot and digit.
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_n = 0;
  bit          m_valid = 1'b0;
  logic [11:0] sh_val;
  logic [2:0]  sh_dp, sh_en;
  logic [3:0]  sh_bri;
  logic [7:0]  exp_bits;
  logic [2:0]  exp_sel;
  logic        exp_dct, exp_ft;
  logic [1:0]  exp_act;

  always @(posedge clk) begin
    int s, d, lit;
    logic [3:0] nib;
    if (reset) begin
      m_n = 0; sh_val = '0; sh_dp = '0; sh_en = '0; sh_bri = '0;
      exp_bits = 8'hFF; exp_sel = 3'b111; exp_dct = 1'b0; exp_ft = 1'b0; exp_act = 2'd0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      s = m_n % T;
      d = (m_n / T) % N;
      if (m_n % (T * N) == 0) begin
        sh_val = bus.digit_values; sh_dp = bus.dp_values;
        sh_en = bus.digit_enable; sh_bri = bus.brightness;
      end
      lit = (sh_bri == 4'd15) ? ON : (ON * int'(sh_bri)) / 16;
      nib = sh_val[4*d +: 4];
      if (s >= B && s < B + lit && sh_en[d]) begin
        exp_sel  = ~(3'b001 << d);
        exp_bits = ~{sh_dp[d], hex_tab[nib]};
      end else begin
        exp_sel  = 3'b111;
        exp_bits = 8'hFF;
      end
      exp_dct = (s == 0);
      exp_ft  = (m_n % (T * N) == 0);
      exp_act = 2'(d);
      m_n++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_bits", 32'(bus.display_bits), 32'(exp_bits));
      check("model_sel", 32'(bus.digit_select), 32'(exp_sel));
      check("model_dct", 32'(bus.digit_change_tick), 32'(exp_dct));
      check("model_ft", 32'(bus.frame_tick), 32'(exp_ft));
      check("model_act", 32'(bus.active_digit), 32'(exp_act));
    end
  end

  task automatic goto(input int target);
    while (pos < target) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic pin(input string name, input logic [2:0] sel, input logic [7:0] bits);
    check({name, "_sel"}, 32'(bus.digit_select), 32'(sel));
    check({name, "_bits"}, 32'(bus.display_bits), 32'(bits));
  endtask

  initial begin
    reset = 1'b1;
    bus.digit_values = 12'h321;
    bus.dp_values    = 3'b000;
    bus.digit_enable = 3'b111;
    bus.brightness   = 4'd15;
    repeat (5) @(negedge clk);
    pin("reset", 3'b111, 8'hFF);
    check("reset_ft", 32'(bus.frame_tick), 32'd0);
    check("reset_dct", 32'(bus.digit_change_tick), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    pos = 0;
    check("first_ft", 32'(bus.frame_tick), 32'd1);
    check("first_dct", 32'(bus.digit_change_tick), 32'd1);
    pin("first_blank", 3'b111, 8'hFF);

    goto(5);   pin("d0_one", 3'b110, 8'hF9);
    goto(25);  pin("d1_two", 3'b101, 8'hA4);
    goto(45);  pin("d2_three", 3'b011, 8'hB0);
    goto(60);  check("frame2_ft", 32'(bus.frame_tick), 32'd1);

    goto(70);  bus.brightness = 4'd8;
    goto(131); pin("bri8_last_lit", 3'b110, 8'hF9);
    goto(132); pin("bri8_off", 3'b111, 8'hFF);
    goto(151); pin("bri8_d1_lit", 3'b101, 8'hA4);
    goto(160); bus.brightness = 4'd0;
    goto(184); pin("bri0_dark", 3'b111, 8'hFF);
    goto(200); check("bri0_dct", 32'(bus.digit_change_tick), 32'd1);
    check("bri0_act", 32'(bus.active_digit), 32'd1);

    goto(190); bus.brightness = 4'd15;
    goto(270); bus.digit_values = 12'hA95;
    goto(285); pin("old_value", 3'b011, 8'hB0);
    goto(305); pin("new_value", 3'b110, 8'h92);

    goto(310); bus.digit_enable = 3'b101; bus.dp_values = 3'b001;
    goto(365); pin("dp_d0", 3'b110, 8'h12);
    goto(385); pin("disabled_d1", 3'b111, 8'hFF);
    goto(405); pin("d2_no_dp", 3'b011, 8'h88);

    goto(449);
    reset = 1'b1;
    @(negedge clk);
    pin("midreset", 3'b111, 8'hFF);
    check("midreset_ft", 32'(bus.frame_tick), 32'd0);
    check("midreset_act", 32'(bus.active_digit), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    pos = 0;
    check("restart_ft", 32'(bus.frame_tick), 32'd1);
    check("restart_act", 32'(bus.active_digit), 32'd0);
    goto(5);   pin("restart_d0", 3'b110, 8'h12);
    goto(70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
